// File: rtl/bcd_stopwatch.sv
// BCD stopwatch / countdown timer with start/stop toggle, lap capture, preload,
// down-count expiry and up-count overflow. Everything is on the rising edge of clock.
module bcd_stopwatch #(
  parameter int CLOCKSPEED = 10000000,
  parameter int TICK_HZ    = 100,
  parameter int NUMCELLS   = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start_stop,
  input  logic                  lap,
  input  logic                  load,
  input  logic [4*NUMCELLS-1:0] load_value,
  input  logic                  down,
  output logic [4*NUMCELLS-1:0] elapsed,
  output logic [4*NUMCELLS-1:0] lap_value,
  output logic                  running,
  output logic                  tick,
  output logic                  expired,
  output logic                  overflow
);

  localparam int DIV = CLOCKSPEED / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int W   = 4 * NUMCELLS;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;
  logic          ss_q, lap_q;
  logic          ss_edge, lap_edge, step;
  logic [W-1:0]  inc_val, dec_val, sat_val;
  logic          all_nines, is_zero, dec_zero, terminal, ss_ignored;

  assign ss_edge  = start_stop & ~ss_q;
  assign lap_edge = lap & ~lap_q;
  assign step     = running && (pre == PRE_LAST);

  // Ripple BCD increment/decrement of the whole count, plus load saturation.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    logic       carry, borrow;
    logic [3:0] d, lv;
    inc_val = '0;
    dec_val = '0;
    sat_val = '0;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < NUMCELLS; i++) begin
      d = elapsed[4*i +: 4];
      if (!carry)          inc_val[4*i +: 4] = d;
      else if (d == 4'd9)  inc_val[4*i +: 4] = 4'd0;
      else begin
        inc_val[4*i +: 4] = d + 4'd1;
        carry = 1'b0;
      end
      if (!borrow)         dec_val[4*i +: 4] = d;
      else if (d == 4'd0)  dec_val[4*i +: 4] = 4'd9;
      else begin
        dec_val[4*i +: 4] = d - 4'd1;
        borrow = 1'b0;
      end
      lv = load_value[4*i +: 4];
      sat_val[4*i +: 4] = (lv > 4'd9) ? 4'd9 : lv;
    end
    // A carry out of the top digit means every digit was 9.
    all_nines = carry;
  end

  assign is_zero    = (elapsed == '0);
  assign dec_zero   = (dec_val == '0);
  assign terminal   = step && (down ? dec_zero : all_nines);
  assign ss_ignored = overflow || (down && is_zero);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clock) begin
    if (rst) begin
      elapsed   <= '0;
      lap_value <= '0;
      pre       <= '0;
      ss_q      <= 1'b0;
      lap_q     <= 1'b0;
      running   <= 1'b0;
      tick      <= 1'b0;
      expired   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      ss_q  <= start_stop;
      lap_q <= lap;
      tick  <= 1'b0;
      if (load) begin
        elapsed  <= sat_val;
        pre      <= '0;
        running  <= 1'b0;
        expired  <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (running) pre <= step ? '0 : pre + PW'(1);
        if (lap_edge) lap_value <= elapsed;

        if (step) begin
          if (!down) begin
            if (all_nines) overflow <= 1'b1;
            else begin
              elapsed <= inc_val;
              tick    <= 1'b1;
            end
          end else begin
            elapsed <= dec_val;
            tick    <= 1'b1;
            if (dec_zero) expired <= 1'b1;
          end
        end

        // A terminal step always stops the count, whatever the start/stop input does.
        if (terminal)                     running <= 1'b0;
        else if (ss_edge && !ss_ignored)  running <= ~running;
      end
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch at DIV=10, NUMCELLS=4; clock period 10 ns.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_bcd_stopwatch;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        start_stop = 1'b0;
  logic        lap = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;
  logic        down = 1'b0;
  logic [15:0] elapsed, lap_value;
  logic        running, tick, expired, overflow;

  int checks = 0;
  int failures = 0;
  int tick_cnt = 0;
  int tick_base;

  bcd_stopwatch #(.CLOCKSPEED(1000), .TICK_HZ(100), .NUMCELLS(4)) dut (
    .clock(clock), .rst(rst), .start_stop(start_stop), .lap(lap), .load(load),
    .load_value(load_value), .down(down), .elapsed(elapsed), .lap_value(lap_value),
    .running(running), .tick(tick), .expired(expired), .overflow(overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    if (tick) tick_cnt++;
  end

  // Stimulus helpers: all are entered and left just after a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    @(negedge clock);
    start_stop = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    @(negedge clock);
    lap = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v, input logic dn);
    load = 1'b1;
    load_value = v;
    down = dn;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (elapsed !== 16'h0000) begin failures++; $display("FAIL reset_elapsed got=%h exp=0000", elapsed); end
    checks++;
    if (lap_value !== 16'h0000) begin failures++; $display("FAIL reset_lap got=%h exp=0000", lap_value); end
    checks++;
    if ({running, tick, expired, overflow} !== 4'b0000)
      begin failures++; $display("FAIL reset_flags got=%b exp=0000", {running, tick, expired, overflow}); end
  endtask

  task automatic test_count_up();
    do_reset();
    pulse_ss();
    tick_base = tick_cnt;
    checks++;
    if (running !== 1'b1) begin failures++; $display("FAIL up_start got=%b exp=1", running); end
    repeat (990) @(negedge clock);
    checks++;
    if (elapsed !== 16'h0099) begin failures++; $display("FAIL up_pre_carry got=%h exp=0099", elapsed); end
    repeat (10) @(negedge clock);
    checks++;
    if (elapsed !== 16'h0100) begin failures++; $display("FAIL up_carry got=%h exp=0100", elapsed); end
    repeat (90) @(negedge clock);
    checks++;
    if (elapsed !== 16'h0109) begin failures++; $display("FAIL up_final got=%h exp=0109", elapsed); end
    checks++;
    if (running !== 1'b1) begin failures++; $display("FAIL up_running got=%b exp=1", running); end
    checks++;
    if (tick_cnt - tick_base !== 109) begin failures++; $display("FAIL up_ticks got=%0d exp=109", tick_cnt - tick_base); end
  endtask

  task automatic test_pause();
    do_reset();
    pulse_ss();
    repeat (24) @(negedge clock);
    pulse_ss();                           // stop lands with pre = 5
    checks++;
    if ({running, elapsed} !== {1'b0, 16'h0002})
      begin failures++; $display("FAIL pause_stop got=%b/%h exp=0/0002", running, elapsed); end
    repeat (50) @(negedge clock);
    checks++;
    if (elapsed !== 16'h0002) begin failures++; $display("FAIL pause_hold got=%h exp=0002", elapsed); end
    pulse_ss();
    repeat (4) @(negedge clock);
    checks++;
    if (elapsed !== 16'h0002) begin failures++; $display("FAIL pause_early got=%h exp=0002", elapsed); end
    @(negedge clock);
    checks++;
    if ({tick, elapsed} !== {1'b1, 16'h0003})
      begin failures++; $display("FAIL pause_resume got=%b/%h exp=1/0003", tick, elapsed); end
  endtask

  task automatic test_lap();
    do_reset();
    pulse_ss();
    repeat (79) @(negedge clock);
    lap = 1'b1;                           // edge coincides with the 7 -> 8 step
    @(negedge clock);
    lap = 1'b0;
    checks++;
    if (lap_value !== 16'h0007) begin failures++; $display("FAIL lap_same_cycle got=%h exp=0007", lap_value); end
    checks++;
    if (elapsed !== 16'h0008) begin failures++; $display("FAIL lap_elapsed got=%h exp=0008", elapsed); end
    pulse_ss();
    checks++;
    if (running !== 1'b0) begin failures++; $display("FAIL lap_stop got=%b exp=0", running); end
    pulse_lap();
    checks++;
    if (lap_value !== 16'h0008) begin failures++; $display("FAIL lap_stopped got=%h exp=0008", lap_value); end
  endtask

  task automatic test_count_down();
    do_reset();
    do_load(16'h0003, 1'b1);
    checks++;
    if (elapsed !== 16'h0003) begin failures++; $display("FAIL down_load got=%h exp=0003", elapsed); end
    pulse_ss();
    repeat (29) @(negedge clock);
    checks++;
    if ({expired, elapsed} !== {1'b0, 16'h0001})
      begin failures++; $display("FAIL down_pre got=%b/%h exp=0/0001", expired, elapsed); end
    @(negedge clock);
    checks++;
    if ({elapsed, expired, running} !== {16'h0000, 1'b1, 1'b0})
      begin failures++; $display("FAIL down_expire got=%h/%b/%b exp=0000/1/0", elapsed, expired, running); end
    pulse_ss();
    repeat (3) @(negedge clock);
    checks++;
    if ({running, elapsed} !== {1'b0, 16'h0000})
      begin failures++; $display("FAIL down_restart got=%b/%h exp=0/0000", running, elapsed); end
  endtask

  task automatic test_overflow();
    do_reset();
    do_load(16'h9999, 1'b0);
    pulse_ss();
    tick_base = tick_cnt;
    repeat (9) @(negedge clock);
    checks++;
    if ({running, overflow} !== 2'b10)
      begin failures++; $display("FAIL ovf_pre got=%b%b exp=10", running, overflow); end
    @(negedge clock);
    checks++;
    if ({elapsed, overflow, running} !== {16'h9999, 1'b1, 1'b0})
      begin failures++; $display("FAIL ovf_hit got=%h/%b/%b exp=9999/1/0", elapsed, overflow, running); end
    checks++;
    if (tick_cnt - tick_base !== 0) begin failures++; $display("FAIL ovf_tick got=%0d exp=0", tick_cnt - tick_base); end
    pulse_ss();
    checks++;
    if (running !== 1'b0) begin failures++; $display("FAIL ovf_ignore got=%b exp=0", running); end
    do_load(16'h1234, 1'b0);
    checks++;
    if ({elapsed, overflow} !== {16'h1234, 1'b0})
      begin failures++; $display("FAIL ovf_reload got=%h/%b exp=1234/0", elapsed, overflow); end
    pulse_ss();
    checks++;
    if (running !== 1'b1) begin failures++; $display("FAIL ovf_restart got=%b exp=1", running); end
  endtask

  task automatic test_load_and_reset();
    do_reset();
    do_load(16'hBCDE, 1'b0);
    checks++;
    if (elapsed !== 16'h9999) begin failures++; $display("FAIL load_sat_all got=%h exp=9999", elapsed); end
    do_load(16'h00A5, 1'b0);
    checks++;
    if (elapsed !== 16'h0095) begin failures++; $display("FAIL load_sat got=%h exp=0095", elapsed); end
    checks++;
    if (tick !== 1'b0) begin failures++; $display("FAIL load_tick got=%b exp=0", tick); end
    pulse_ss();
    repeat (25) @(negedge clock);
    pulse_lap();
    checks++;
    if (lap_value !== 16'h0097) begin failures++; $display("FAIL load_lap got=%h exp=0097", lap_value); end
    rst = 1'b1;
    start_stop = 1'b1;
    lap = 1'b1;
    load = 1'b1;
    load_value = 16'h4321;
    @(negedge clock);
    rst = 1'b0;
    start_stop = 1'b0;
    lap = 1'b0;
    load = 1'b0;
    checks++;
    if ({elapsed, lap_value} !== 32'h0)
      begin failures++; $display("FAIL rst_values got=%h/%h exp=0000/0000", elapsed, lap_value); end
    checks++;
    if ({running, tick, expired, overflow} !== 4'b0000)
      begin failures++; $display("FAIL rst_flags got=%b exp=0000", {running, tick, expired, overflow}); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_count_up();
    test_pause();
    test_lap();
    test_count_down();
    test_overflow();
    test_load_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch.md
# bcd_stopwatch

Parametrised BCD stopwatch/countdown timer: the successor to the single-mode 4-digit elapsed-time counter used for the 7-segment display path. Counts up or down in BCD at a configurable tick rate across NUMCELLS digits. Adds start/stop toggling, lap capture, preload, down-count expiry and up-count overflow. Sits between the button inputs and the segment multiplexer, which consumes `elapsed` or `lap_value` directly.

## Interface
- CLOCKSPEED, 10000000: clock frequency in Hz.
- TICK_HZ, 100: count rate. The prescaler divisor is DIV = CLOCKSPEED/TICK_HZ, which must be ≥ 2.
- NUMCELLS, 4: number of BCD digits, ≥ 1.

Ports:
- clock  in  1  system clock. All logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start_stop  in  1  level input. Its rising edge toggles run/stop.
- lap  in  1  level input. Its rising edge captures `elapsed` into `lap_value`.
- load  in  1  level input. While high, preloads `load_value`.
- load_value  in  4*NUMCELLS  BCD preload value. Digit 0 is bits [3:0].
- down  in  1  count direction: 1 = down, 0 = up. Sampled at each tick.
- elapsed  out  4*NUMCELLS  current BCD count. Registered.
- lap_value  out  4*NUMCELLS  last captured count. Registered.
- running  out  1  counting enabled.
- tick  out  1  one-cycle pulse on the cycle the count changes.
- expired  out  1  sticky flag: a down-count reached zero.
- overflow  out  1  sticky flag: an up-count was attempted at all nines.

All inputs are synchronous to `clock`. Debouncing and synchronisation happen upstream.

## Operation
- Edge detection: registers `ss_q` and `lap_q` hold the previous sample of each input. An edge event is `in & ~in_q`, evaluated at the clock edge. Both registers reset to 0.
- Prescaler: `pre` counts 0..DIV-1 and increments only while `running` is high. The count step fires when `running` is high and `pre == DIV-1`; at that point `pre` returns to 0. While stopped, `pre` holds its value, so a partial interval is preserved across a pause.
- Up step: digit 0 increments. Any digit at 9 becomes 0 and carries into the next digit. If every digit is 9, the digits stay at all nines, `overflow` is set to 1 and `running` is cleared to 0.
- Down step: digit 0 decrements. Any digit at 0 becomes 9 and borrows from the next digit. If the step produces all zeros, `expired` is set to 1 and `running` is cleared to 0 on that same edge.
- Start/stop edge toggles `running`, with two exceptions where it is ignored and `running` stays 0:
  - `overflow` is set.
  - `down` is 1 and `elapsed` is zero.
- Load: `elapsed` takes `load_value`, with any nibble greater than 9 forced to 9. Load also clears `pre`, `running`, `expired` and `overflow`. Load does not change `lap_value`.
- Lap edge: `lap_value` takes the `elapsed` value from before this edge, i.e. excluding any step on the same cycle. Capture works whether running or stopped.
- Priority per cycle: rst > load > (step, start/stop, lap evaluated together).
  - If a step and a stop edge coincide, the step is applied and `running` ends at 0.
  - Start/stop edges arriving while `load` is high are consumed and have no effect.

## Timing
- Reset values: `elapsed`, `lap_value`, `pre`, `ss_q` and `lap_q` = 0. `running`, `tick`, `expired` and `overflow` = 0.
- Start latency: the start edge is accepted at edge E0, with `pre` still 0. `pre` reaches 1..DIV-1 on E1..E(DIV-1). The first step lands on E(DIV), so `elapsed` changes DIV cycles after E0.
- `tick` is high for exactly one cycle after each edge that changes `elapsed`. It is not asserted by load.
- Overflow and expiry are visible on the same edge as the terminal step. `tick` does not pulse for an overflow step, because the value is unchanged.
- Reset mid-run takes effect on the next edge regardless of other inputs.

## Test plan
Bench parameters: CLOCKSPEED=1000, TICK_HZ=100 (DIV=10), NUMCELLS=4.

1. Reset, then one start_stop pulse, then run 1090 cycles → `elapsed` = 0x0109, `running` = 1, 109 `tick` pulses seen. Check the carry 0x0099 → 0x0100.
2. Start, run 25 cycles (`elapsed` = 0x0002, `pre` = 5), stop, idle 50 cycles, restart → `elapsed` holds 0x0002 while stopped, then becomes 0x0003 exactly 5 cycles after the restart edge.
3. Lap edge on the same cycle as a tick step from 0x0007 → `lap_value` = 0x0007, `elapsed` = 0x0008. A lap edge while stopped also captures.
4. Load 0x0003, down=1, start, run 30 cycles → `elapsed` = 0x0000, `expired` = 1, `running` = 0. A further start edge is ignored.
5. Load 0x9999, up, start, run 10 cycles → `elapsed` = 0x9999, `overflow` = 1, `running` = 0, no `tick` pulse. Start is ignored until a load.
6. Load 0x00A5 → `elapsed` = 0x0095. Then a start, then `rst` held for 1 cycle mid-run → every output is 0 on the next cycle.
